// File: rtl/nes_oam_dma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nes_oam_dma : sprite DMA engine, copies one CPU page to the OAM data port |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module nes_oam_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004,
  parameter int unsigned XFER_LEN  = 256
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  output logic        o_spr_req,
  input  logic        i_spr_gnt,
  output logic [15:0] o_spr_addr,
  output logic        o_spr_wn,
  output logic [7:0]  o_spr_wdata,
  input  logic [7:0]  i_spr_rdata,
  output logic        o_busy
);

  localparam logic [7:0] C_LAST = 8'(XFER_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  page_q;
  logic [7:0]  cnt_q;
  logic        req_q;
  logic        wn_q;
  logic        busy_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        w_trig;

  assign w_trig = !i_bus_wn && (i_bus_addr == TRIG_ADDR);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      cnt_q   <= 8'h00;
      req_q   <= 1'b0;
      wn_q    <= 1'b1;
      busy_q  <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_trig) begin
            page_q  <= i_bus_wdata;
            cnt_q   <= 8'h00;
            state_q <= S_RD;
            req_q   <= 1'b1;
            wn_q    <= 1'b1;
            addr_q  <= {i_bus_wdata, 8'h00};
            busy_q  <= 1'b1;
          end
        end
        S_RD: begin
          // wdata_q doubles as the captured byte; held until its write is granted
          if (i_spr_gnt) begin
            wdata_q <= i_spr_rdata;
            state_q <= S_WR;
            wn_q    <= 1'b0;
            addr_q  <= OAM_ADDR;
          end
        end
        S_WR: begin
          if (i_spr_gnt) begin
            wn_q <= 1'b1;
            if (cnt_q == C_LAST) begin
              state_q <= S_DONE;
              req_q   <= 1'b0;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              state_q <= S_RD;
              addr_q  <= {page_q, cnt_q + 8'd1};
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_spr_req   = req_q;
  assign o_spr_addr  = addr_q;
  assign o_spr_wn    = wn_q;
  assign o_spr_wdata = wdata_q;
  assign o_busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_nes_oam_dma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nes_oam_dma : directed and random-grant bench for the sprite DMA       |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_nes_oam_dma;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic        gnt;
  logic        spr_req;
  logic [15:0] spr_addr;
  logic        spr_wn;
  logic [7:0]  spr_wdata;
  logic [7:0]  spr_rdata;
  logic        busy;

  logic [7:0]  mem [0:65535];

  always #5 clk = ~clk;

  assign spr_rdata = mem[spr_addr];

  nes_oam_dma dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_bus_addr  (bus_addr),
    .i_bus_wn    (bus_wn),
    .i_bus_wdata (bus_wdata),
    .o_spr_req   (spr_req),
    .i_spr_gnt   (gnt),
    .o_spr_addr  (spr_addr),
    .o_spr_wn    (spr_wn),
    .o_spr_wdata (spr_wdata),
    .i_spr_rdata (spr_rdata),
    .o_busy      (busy)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] q_addr [$];
  logic        q_wn   [$];
  logic [7:0]  q_data [$];
  logic        prev_stall = 1'b0;
  logic [25:0] saved_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive inputs at the falling edge, log the access that the next rising edge executes.
  task automatic step(input logic g, input logic [15:0] a, input logic w, input logic [7:0] d);
    @(negedge clk);
    if (prev_stall)
      check("stall_hold", {6'd0, spr_req, spr_addr, spr_wn, spr_wdata}, {6'd0, saved_out});
    gnt = g; bus_addr = a; bus_wn = w; bus_wdata = d;
    #1;
    if (spr_req && gnt) begin
      q_addr.push_back(spr_addr);
      q_wn.push_back(spr_wn);
      q_data.push_back(spr_wn ? spr_rdata : spr_wdata);
    end
    prev_stall = spr_req && !gnt;
    saved_out  = {spr_req, spr_addr, spr_wn, spr_wdata};
  endtask

  task automatic idle(input logic g);
    step(g, 16'h0000, 1'b1, 8'h00);
  endtask

  task automatic trigger(input logic [7:0] page);
    step(1'b1, 16'h4014, 1'b0, page);
  endtask

  task automatic run_to_idle(input int budget, input bit rnd);
    int n = 0;
    do begin
      idle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end while (busy && n < budget);
    check("xfer_timeout_busy", {31'd0, busy}, 32'd0);
  endtask

  // Reference: 256 pairs of (read page:i, write OAM with mem[page:i]).
  task automatic check_seq(input string tag, input logic [7:0] page);
    int n;
    logic [15:0] ea;
    check({tag, "_count"}, q_addr.size(), 32'd512);
    n = (q_addr.size() < 512) ? q_addr.size() : 512;
    for (int k = 0; k < n; k++) begin
      ea = {page, 8'(k / 2)};
      check({tag, "_access"}, {7'd0, q_addr[k], q_wn[k], q_data[k]},
            {7'd0, (k % 2 == 0) ? ea : 16'h2004, (k % 2 == 0), mem[ea]});
    end
    q_addr.delete(); q_wn.delete(); q_data.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFFF] = 8'hA5;
    rstn = 1'b0; gnt = 1'b0; bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {5'd0, spr_req, spr_addr, spr_wn, spr_wdata, busy},
          {5'd0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});
    @(negedge clk); rstn = 1'b1;

    // CPU writes to other registers must not start a transfer
    step(1'b1, 16'h4015, 1'b0, 8'h02);
    step(1'b1, 16'h2004, 1'b0, 8'h02);
    step(1'b1, 16'h4014, 1'b1, 8'h02);
    for (int j = 0; j < 3; j++) begin
      idle(1'b1);
      check("no_trigger_idle", {30'd0, spr_req, busy}, 32'd0);
    end

    // Continuous grant, page $02, exact cycle timing
    trigger(8'h02);
    check("trig_cycle_req", {30'd0, spr_req, busy}, 32'd0);
    for (int j = 1; j <= 514; j++) begin
      idle(1'b1);
      check("t1_req_busy", {30'd0, spr_req, busy}, {30'd0, 1'(j <= 512), 1'(j <= 513)});
    end
    check_seq("t1", 8'h02);

    // Random grant, page $03
    trigger(8'h03);
    run_to_idle(4000, 1'b1);
    check_seq("t2", 8'h03);

    // Held trigger, re-trigger mid-transfer and during DONE are all ignored
    trigger(8'h02);
    trigger(8'h09);
    for (int j = 2; j <= 514; j++) begin
      if (j == 100)      trigger(8'h05);
      else if (j == 513) trigger(8'h07);
      else               idle(1'b1);
    end
    check_seq("t3", 8'h02);
    for (int j = 0; j < 5; j++) begin
      idle(1'b1);
      check("t3_no_second_xfer", {30'd0, spr_req, busy}, 32'd0);
    end
    check("t3_no_extra_access", q_addr.size(), 32'd0);

    // Page $FF wraps within the page only
    trigger(8'hFF);
    run_to_idle(4000, 1'b1);
    check("t4_last_data", (q_data.size() > 0) ? {24'd0, q_data[$]} : 32'hFFFF_FFFF, 32'h0000_00A5);
    check_seq("t4", 8'hFF);

    // Asynchronous reset mid-transfer, then a fresh transfer
    trigger(8'h04);
    for (int j = 0; j < 100; j++) idle(1'b1);
    @(negedge clk); #2 rstn = 1'b0; #1;
    check("t5_async_reset", {5'd0, spr_req, spr_addr, spr_wn, spr_wdata, busy},
          {5'd0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});
    prev_stall = 1'b0;
    q_addr.delete(); q_wn.delete(); q_data.delete();
    @(negedge clk); rstn = 1'b1;
    idle(1'b1);
    check("t5_idle_after_reset", {30'd0, spr_req, busy}, 32'd0);
    trigger(8'h06);
    run_to_idle(4000, 1'b1);
    check_seq("t5", 8'h06);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
